exec_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32 core. It fetches each instruction over a valid/ready instruction-memory handshake, latches it, and decodes the opcode to select one functional unit. It then drives that unit's active-low enable for the two-cycle register-select/resolve window and updates the program counter from the unit's redirect outputs or PC+4. It owns `program_counter` and `instruction` for the whole execute side, including the branch unit.

---
 rtl/exec_sequencer.sv | 173 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the RV32 core.
// Optional performance counters are built only when EXEC_PERF_COUNTERS_EN is defined.
module exec_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_request,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] program_counter,
  output logic            branch_enable_n,
  output logic            arith_enable_n,
  input  logic            load_new_program_counter,
  input  logic [XLEN-1:0] new_program_counter,
  output logic            register_write_enable,
  output logic            retired,
  output logic            illegal_instruction,
  output logic            misaligned_fault,
  output logic            halted,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retire_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_SELECT,
    S_RESOLVE,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    UNIT_NONE,
    UNIT_BRANCH,
    UNIT_ARITH
  } unit_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_e          state_q, state_d;
  unit_e           unit_q, unit_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            started_q;
  logic            illegal_q, illegal_d;
  logic            misaligned_q, misaligned_d;

  logic            exec_window;
  logic            redirect_fault;
  logic [6:0]      opcode;

  assign opcode         = instr_q[6:0];
  assign exec_window    = (state_q == S_SELECT) || (state_q == S_RESOLVE);
  assign redirect_fault = load_new_program_counter && (new_program_counter[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      unit_q       <= UNIT_NONE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      started_q    <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_q       <= unit_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      started_q    <= 1'b1;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Redirect inputs are only looked at in S_RESOLVE so floating values from idle units never leak in.
  always_comb begin
    state_d      = state_q;
    unit_d       = unit_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    illegal_d    = illegal_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_FETCH: begin
        if (started_q && imem_ready) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OPC_BRANCH) begin
          unit_d  = UNIT_BRANCH;
          state_d = S_SELECT;
        end else if ((opcode == OPC_OP_IMM) || (opcode == OPC_OP)) begin
          unit_d  = UNIT_ARITH;
          state_d = S_SELECT;
        end else begin
          unit_d    = UNIT_NONE;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_SELECT: begin
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        unit_d = UNIT_NONE;
        if (redirect_fault) begin
          misaligned_d = 1'b1;
          state_d      = S_HALT;
        end else begin
          pc_d    = load_new_program_counter ? new_program_counter : (pc_q + XLEN'(4));
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_request          = (state_q == S_FETCH) && started_q;
  assign imem_address          = pc_q;
  assign instruction           = instr_q;
  assign program_counter       = pc_q;
  assign branch_enable_n       = !(exec_window && (unit_q == UNIT_BRANCH));
  assign arith_enable_n        = !(exec_window && (unit_q == UNIT_ARITH));
  assign register_write_enable = (state_q == S_RESOLVE) && (unit_q == UNIT_ARITH);
  assign retired               = (state_q == S_RESOLVE) && !redirect_fault;
  assign illegal_instruction   = illegal_q;
  assign misaligned_fault      = misaligned_q;
  assign halted                = (state_q == S_HALT);

`ifdef EXEC_PERF_COUNTERS_EN
  logic [31:0] cycle_q;
  logic [31:0] retire_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + 32'd1;
      if (retired)           retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
`else
  assign cycle_count  = 32'd0;
  assign retire_count = 32'd0;
`endif

  // Structural invariants of the sequencer's outputs.
  a_single_enable: assert property (@(posedge clk) disable iff (!reset_n)
    !(!branch_enable_n && !arith_enable_n));
  a_request_held: assert property (@(posedge clk) disable iff (!reset_n)
    (imem_request && !imem_ready) |=> (imem_request && $stable(imem_address)));
  a_halt_sticky: assert property (@(posedge clk) disable iff (!reset_n)
    halted |=> halted);

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized self-checking bench for exec_sequencer against an instruction-level reference model.
module tb_exec_sequencer;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef EXEC_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instruction;
  logic [31:0] program_counter;
  logic        branch_enable_n;
  logic        arith_enable_n;
  logic        load_new_program_counter = 1'b0;
  logic [31:0] new_program_counter = '0;
  logic        register_write_enable;
  logic        retired;
  logic        illegal_instruction;
  logic        misaligned_fault;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural state at instruction granularity.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_instr = '0;
  logic [31:0] m_ret = '0;
  logic [31:0] m_cyc = '0;
  bit          m_halted = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_cyc <= '0;
    else if (!m_halted) m_cyc <= m_cyc + 32'd1;
  end

  exec_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .imem_request             (imem_request),
    .imem_address             (imem_address),
    .imem_ready               (imem_ready),
    .imem_data                (imem_data),
    .instruction              (instruction),
    .program_counter          (program_counter),
    .branch_enable_n          (branch_enable_n),
    .arith_enable_n           (arith_enable_n),
    .load_new_program_counter (load_new_program_counter),
    .new_program_counter      (new_program_counter),
    .register_write_enable    (register_write_enable),
    .retired                  (retired),
    .illegal_instruction      (illegal_instruction),
    .misaligned_fault         (misaligned_fault),
    .halted                   (halted),
    .cycle_count              (cycle_count),
    .retire_count             (retire_count)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ready = 1'b0;
    imem_data = $urandom;
    load_new_program_counter = 1'($urandom);
    new_program_counter = $urandom;
    m_halted = 1'b0;
    m_ret = '0;
    m_pc = RESET_PC;
    m_instr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (imem_request !== 1'b0) begin errors++; $display("FAIL rst_first_req got=%b exp=0", imem_request); end
    checks++; if (imem_address !== RESET_PC) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_address, RESET_PC); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instruction); end
    checks++; if ({branch_enable_n, arith_enable_n} !== 2'b11) begin errors++; $display("FAIL rst_enables got=%b exp=11", {branch_enable_n, arith_enable_n}); end
    checks++; if ({register_write_enable, retired} !== 2'b00) begin errors++; $display("FAIL rst_we_ret got=%b exp=00", {register_write_enable, retired}); end
    checks++; if ({illegal_instruction, misaligned_fault, halted} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {illegal_instruction, misaligned_fault, halted}); end
    checks++; if ({cycle_count, retire_count} !== 64'h0) begin errors++; $display("FAIL rst_counters got=%h/%h exp=0/0", cycle_count, retire_count); end
    @(negedge clk);
    #1;
    checks++; if (imem_request !== 1'b1) begin errors++; $display("FAIL rst_second_req got=%b exp=1", imem_request); end
    checks++; if (cycle_count !== (PERF ? m_cyc : 32'h0)) begin errors++; $display("FAIL rst_cycle1 got=%0d exp=%0d", cycle_count, PERF ? m_cyc : 32'h0); end
  endtask

  // Runs one instruction from a FETCH cycle (called just after a negedge) to the next FETCH or HALT.
  task automatic do_instr(input logic [31:0] instr, input int waits, input bit redir, input logic [31:0] target);
    bit br, ar, fault;
    br = (instr[6:0] == 7'b1100011);
    ar = (instr[6:0] == 7'b0010011) || (instr[6:0] == 7'b0110011);
    fault = redir && (target[1:0] != 2'b00);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_data = $urandom;
      #1;
      checks++; if (imem_request !== 1'b1) begin errors++; $display("FAIL wait_req got=%b exp=1", imem_request); end
      checks++; if (imem_address !== m_pc) begin errors++; $display("FAIL wait_addr got=%h exp=%h", imem_address, m_pc); end
      checks++; if (instruction !== m_instr) begin errors++; $display("FAIL wait_instr got=%h exp=%h", instruction, m_instr); end
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_data = instr;
    #1;
    checks++; if (imem_request !== 1'b1) begin errors++; $display("FAIL fetch_req got=%b exp=1", imem_request); end
    checks++; if (imem_address !== m_pc) begin errors++; $display("FAIL fetch_addr got=%h exp=%h", imem_address, m_pc); end
    @(negedge clk);
    imem_ready = 1'b0;
    imem_data = $urandom;
    load_new_program_counter = 1'($urandom);
    new_program_counter = $urandom;
    m_instr = instr;
    #1;
    checks++; if (instruction !== m_instr) begin errors++; $display("FAIL dec_instr got=%h exp=%h", instruction, m_instr); end
    checks++; if (imem_request !== 1'b0) begin errors++; $display("FAIL dec_req got=%b exp=0", imem_request); end
    checks++; if ({branch_enable_n, arith_enable_n, retired} !== 3'b110) begin errors++; $display("FAIL dec_en_ret got=%b exp=110", {branch_enable_n, arith_enable_n, retired}); end
    if (!(br || ar)) begin
      @(negedge clk);
      m_halted = 1'b1;
      #1;
      checks++; if ({illegal_instruction, halted, misaligned_fault} !== 3'b110) begin errors++; $display("FAIL ill_flags got=%b exp=110", {illegal_instruction, halted, misaligned_fault}); end
      checks++; if ({imem_request, branch_enable_n, arith_enable_n} !== 3'b011) begin errors++; $display("FAIL ill_outs got=%b exp=011", {imem_request, branch_enable_n, arith_enable_n}); end
      return;
    end
    @(negedge clk);
    load_new_program_counter = 1'($urandom);
    new_program_counter = $urandom;
    #1;
    checks++; if ({branch_enable_n, arith_enable_n} !== {!br, !ar}) begin errors++; $display("FAIL sel_enables got=%b exp=%b", {branch_enable_n, arith_enable_n}, {!br, !ar}); end
    checks++; if ({register_write_enable, retired, imem_request} !== 3'b000) begin errors++; $display("FAIL sel_we_ret_req got=%b exp=000", {register_write_enable, retired, imem_request}); end
    @(negedge clk);
    load_new_program_counter = redir;
    new_program_counter = target;
    #1;
    checks++; if ({branch_enable_n, arith_enable_n} !== {!br, !ar}) begin errors++; $display("FAIL res_enables got=%b exp=%b", {branch_enable_n, arith_enable_n}, {!br, !ar}); end
    checks++; if (register_write_enable !== ar) begin errors++; $display("FAIL res_we got=%b exp=%b", register_write_enable, ar); end
    checks++; if (retired !== !fault) begin errors++; $display("FAIL res_retired got=%b exp=%b", retired, !fault); end
    checks++; if (program_counter !== m_pc) begin errors++; $display("FAIL res_pc got=%h exp=%h", program_counter, m_pc); end
    @(negedge clk);
    load_new_program_counter = 1'($urandom);
    new_program_counter = $urandom;
    if (fault) begin
      m_halted = 1'b1;
      #1;
      checks++; if ({misaligned_fault, halted, retired} !== 3'b110) begin errors++; $display("FAIL mis_flags got=%b exp=110", {misaligned_fault, halted, retired}); end
      checks++; if (program_counter !== m_pc) begin errors++; $display("FAIL mis_pc got=%h exp=%h", program_counter, m_pc); end
      checks++; if ({imem_request, branch_enable_n, arith_enable_n} !== 3'b011) begin errors++; $display("FAIL mis_outs got=%b exp=011", {imem_request, branch_enable_n, arith_enable_n}); end
    end else begin
      m_ret = m_ret + 32'd1;
      m_pc = redir ? target : (m_pc + 32'd4);
      #1;
      checks++; if (imem_request !== 1'b1) begin errors++; $display("FAIL next_req got=%b exp=1", imem_request); end
      checks++; if (imem_address !== m_pc) begin errors++; $display("FAIL next_addr got=%h exp=%h", imem_address, m_pc); end
      checks++; if ({branch_enable_n, arith_enable_n, halted} !== 3'b110) begin errors++; $display("FAIL next_outs got=%b exp=110", {branch_enable_n, arith_enable_n, halted}); end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_arith_sequence();
    do_reset();
    for (int k = 0; k < 3; k++) do_instr(32'h0000_0013, 0, 1'b0, 32'h0);
    checks++; if (imem_address !== 32'h0000_000C) begin errors++; $display("FAIL arith_seq_addr got=%h exp=0000000c", imem_address); end
    checks++; if (retire_count !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL arith_seq_retire got=%0d exp=%0d", retire_count, PERF ? 3 : 0); end
    checks++; if (cycle_count !== (PERF ? m_cyc : 32'h0)) begin errors++; $display("FAIL arith_seq_cycles got=%0d exp=%0d", cycle_count, PERF ? m_cyc : 32'h0); end
  endtask

  task automatic test_branch();
    do_reset();
    do_instr(32'h0000_0463, 0, 1'b1, 32'h0000_0010);
    checks++; if (imem_address !== 32'h0000_0010) begin errors++; $display("FAIL branch_target got=%h exp=00000010", imem_address); end
  endtask

  task automatic test_fetch_wait();
    logic [31:0] c0;
    do_reset();
    c0 = m_cyc;
    do_instr(32'h0000_0033, 3, 1'b0, 32'h0);
    checks++; if ((m_cyc - c0) !== 32'd7 || cycle_count !== (PERF ? m_cyc : 32'h0)) begin errors++; $display("FAIL wait_latency got=%0d exp=%0d", cycle_count, PERF ? m_cyc : 32'h0); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    do_instr(32'h0000_0063, 1, 1'b1, 32'hFFFF_FFFC);
    do_instr(32'h0000_0013, 0, 1'b0, 32'h0);
    checks++; if (imem_address !== 32'h0) begin errors++; $display("FAIL pc_wrap got=%h exp=00000000", imem_address); end
  endtask

  task automatic test_illegal();
    logic [31:0] cyc_frozen;
    do_reset();
    do_instr(32'h0000_0013, 0, 1'b0, 32'h0);
    do_instr(32'h0000_2003, 0, 1'b0, 32'h0);
    cyc_frozen = m_cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      load_new_program_counter = 1'($urandom);
      #1;
      checks++; if ({imem_request, halted, illegal_instruction} !== 3'b011) begin errors++; $display("FAIL ill_hold got=%b exp=011", {imem_request, halted, illegal_instruction}); end
    end
    checks++; if (cycle_count !== (PERF ? cyc_frozen : 32'h0)) begin errors++; $display("FAIL ill_cycles_frozen got=%0d exp=%0d", cycle_count, PERF ? cyc_frozen : 32'h0); end
    imem_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_misaligned();
    do_reset();
    do_instr(32'h0000_0463, 0, 1'b1, 32'h0000_0012);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({imem_request, halted, misaligned_fault, retired} !== 4'b0110) begin errors++; $display("FAIL mis_hold got=%b exp=0110", {imem_request, halted, misaligned_fault, retired}); end
    end
    checks++; if (retire_count !== 32'h0) begin errors++; $display("FAIL mis_retire got=%0d exp=0", retire_count); end
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    do_instr(32'h0000_0013, 0, 1'b0, 32'h0);
    imem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({imem_request, halted} !== 2'b00) begin errors++; $display("FAIL arst_fetch_req got=%b exp=00", {imem_request, halted}); end
    checks++; if ({program_counter, instruction} !== {RESET_PC, 32'h0}) begin errors++; $display("FAIL arst_fetch_state got=%h/%h exp=%h/0", program_counter, instruction, RESET_PC); end
    do_reset();
    imem_ready = 1'b1;
    imem_data = 32'h0000_0013;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load_new_program_counter = 1'b0;
    #1;
    checks++; if ({arith_enable_n, register_write_enable} !== 2'b01) begin errors++; $display("FAIL arst_pre_resolve got=%b exp=01", {arith_enable_n, register_write_enable}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({branch_enable_n, arith_enable_n, register_write_enable, retired} !== 4'b1100) begin errors++; $display("FAIL arst_res_outs got=%b exp=1100", {branch_enable_n, arith_enable_n, register_write_enable, retired}); end
    checks++; if ({program_counter, instruction} !== {RESET_PC, 32'h0}) begin errors++; $display("FAIL arst_res_state got=%h/%h exp=%h/0", program_counter, instruction, RESET_PC); end
    checks++; if ({cycle_count, retire_count} !== 64'h0) begin errors++; $display("FAIL arst_counters got=%h/%h exp=0/0", cycle_count, retire_count); end
    do_reset();
    for (int k = 0; k < 5; k++) do_instr(32'h0000_0013, k % 2, 1'b0, 32'h0);
    checks++; if (retire_count !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL arst_retire_n got=%0d exp=%0d", retire_count, PERF ? 5 : 0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int          sel;
      logic [31:0] ins;
      sel = int'($urandom_range(0, 2));
      ins = $urandom;
      ins[6:0] = (sel == 0) ? 7'b0010011 : (sel == 1) ? 7'b0110011 : 7'b1100011;
      do_instr(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
    end
    checks++; if (retire_count !== (PERF ? m_ret : 32'h0)) begin errors++; $display("FAIL rand_retire got=%0d exp=%0d", retire_count, PERF ? m_ret : 32'h0); end
    checks++; if (cycle_count !== (PERF ? m_cyc : 32'h0)) begin errors++; $display("FAIL rand_cycles got=%0d exp=%0d", cycle_count, PERF ? m_cyc : 32'h0); end
  endtask

  initial begin
    test_reset();
    test_arith_sequence();
    test_branch();
    test_fetch_wait();
    test_pc_wrap();
    test_illegal();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
